clock_gen: RTL and testbench
============================

// Module: clock_gen
// PURPOSE
//  Clock/reset source for the single-cycle MIPS datapath.
//  - Divides the reference clock into a 50%-duty (odd N: high one extra cycle) core clock clk_out.
//  - Emits single-cycle rise/fall ticks in the clk domain.
//  - Issues a stretched power-on reset (sys_reset_n) so PC and register file start cleanly.
//  - Maintains a free-running core-cycle counter for debug/CPI measurement.
// PARAMETERS
//  DIV_WIDTH    8   width of div input and internal divide counter
//  DEFAULT_DIV  2   divide ratio used from reset until first period boundary (>=2)
//  POR_CYCLES   4   clk_out rising edges sys_reset_n stays low after reset release
// PORTS
//  clk          in   1          reference clock; all logic on posedge
//  reset        in   1          asynchronous, active-low (0 = asserted)
//  en           in   1          1 = generator runs; 0 = freeze all state
//  div          in   DIV_WIDTH  requested divide ratio N; values 0/1 treated as 2
//  clk_out      out  1          generated core clock (registered, glitch-free)
//  rise_tick    out  1          1-cycle pulse on the clk edge where clk_out goes 0->1
//  fall_tick    out  1          1-cycle pulse on the clk edge where clk_out goes 1->0
//  sys_reset_n  out  1          stretched active-low reset for downstream logic
//  cycle_count  out  32         count of clk_out rising edges since reset
// BEHAVIOUR
//  - Reset (reset==0, async, immediate; also mid-operation):
//    clk_out=0, rise_tick=0, fall_tick=0, sys_reset_n=0, cycle_count=0,
//    active ratio N=DEFAULT_DIV, cnt=DEFAULT_DIV-1, por_cnt=0.
//  - H = ceil(N/2) = high phase length. clk_out=1 for cnt 0..H-1, 0 for cnt H..N-1.
//  - Each posedge clk with en=1:
//    - cnt==N-1 (boundary): cnt<=0; N<=max(div,2); clk_out<=1; rise_tick<=1;
//      cycle_count<=cycle_count+1 (wraps 2^32-1 -> 0).
//    - else: cnt<=cnt+1; if cnt+1==H (H of current N): clk_out<=0, fall_tick<=1.
//    - Ticks are 0 on every edge not listed above.
//  - First enabled edge after reset release is a boundary: clk_out rises one clk cycle later.
//  - div sampled only at the boundary; mid-period changes never shorten or glitch a phase.
//  - en=0: cnt, N, clk_out, cycle_count, por_cnt hold; ticks forced 0.
//    Resuming continues the same period exactly where frozen.
//  - sys_reset_n: por_cnt increments on each rise_tick, saturating at POR_CYCLES.
//    sys_reset_n<=1 on the clk edge after por_cnt reaches POR_CYCLES; stays 1 until reset.
//  - All outputs registered; no combinational path from inputs to outputs.
// TESTING
//  - Reset: reset=0 -> all outputs 0 at once, even mid-high-phase with en=1.
//  - Default: release, en=1, div=2 -> clk_out 1,0,1,0... per clk; rise_tick every 2nd clk;
//    cycle_count 1,1,2,2...
//  - Odd ratio: div=5 -> clk_out high 3 clk, low 2 clk; fall_tick 3 clk after each rise_tick.
//    Switch div 5->3 mid-period -> current period finishes at 5, next is 3 (high 2/low 1).
//  - Illegal: div=0 and div=1 -> identical waveform to div=2.
//  - Freeze: en=0 for 7 clk mid-high-phase -> clk_out stays 1, no ticks, cycle_count constant;
//    en=1 -> remaining high cycles complete.
//  - POR: POR_CYCLES=4, div=2 -> sys_reset_n 0 through 4th rise_tick, 1 on next clk edge.
//    reset low again -> sys_reset_n=0 immediately.

Source files
------------

// File: rtl/clock_gen_if.sv
// Control and output bundle of the core clock generator.
// master = generator side, slave = consumer that sets en/div and watches the clock.
interface clock_gen_if #(
  parameter int DIV_WIDTH = 8
);
  logic                 en;
  logic [DIV_WIDTH-1:0] div;
  logic                 clk_out;
  logic                 rise_tick;
  logic                 fall_tick;
  logic                 sys_reset_n;
  logic [31:0]          cycle_count;

  modport master (
    input  en, div,
    output clk_out, rise_tick, fall_tick, sys_reset_n, cycle_count
  );

  modport slave (
    output en, div,
    input  clk_out, rise_tick, fall_tick, sys_reset_n, cycle_count
  );
endinterface

// File: rtl/clock_gen.sv
// Core clock divider with edge ticks, stretched power-on reset and core-cycle counter.
// All outputs are registered in the reference clock domain.
module clock_gen #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int POR_CYCLES  = 4
) (
  input  logic         clk,
  input  logic         reset,
  clock_gen_if.master  bus
);

  localparam int POR_W = (POR_CYCLES < 1) ? 1 : $clog2(POR_CYCLES + 1);
  localparam logic [DIV_WIDTH-1:0] DEF_N   = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] MIN_N   = DIV_WIDTH'(2);
  localparam logic [POR_W-1:0]     POR_MAX = POR_W'(POR_CYCLES);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] n_act;
  logic [DIV_WIDTH-1:0] n_next;
  logic [DIV_WIDTH:0]   high_len;
  logic                 boundary;
  logic                 fall_now;

  logic                 clk_out_q;
  logic                 rise_q;
  logic                 fall_q;
  logic                 sys_reset_n_q;
  logic [31:0]          cycle_count_q;
  logic [POR_W-1:0]     por_cnt;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    n_next   = (bus.div < MIN_N) ? MIN_N : bus.div;
    // One extra bit so ceil(N/2) cannot overflow at the largest ratio.
    high_len = ({1'b0, n_act} + (DIV_WIDTH+1)'(1)) >> 1;
    boundary = (cnt == n_act - DIV_WIDTH'(1));
    fall_now = (({1'b0, cnt} + (DIV_WIDTH+1)'(1)) == high_len);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt           <= DEF_N - DIV_WIDTH'(1);
      n_act         <= DEF_N;
      clk_out_q     <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (bus.en) begin
        if (boundary) begin
          // The ratio is only taken here, so a running period is never cut short.
          cnt           <= '0;
          n_act         <= n_next;
          clk_out_q     <= 1'b1;
          rise_q        <= 1'b1;
          cycle_count_q <= cycle_count_q + 32'd1;
        end else begin
          cnt <= cnt + DIV_WIDTH'(1);
          if (fall_now) begin
            clk_out_q <= 1'b0;
            fall_q    <= 1'b1;
          end
        end
      end
    end
  end

  // Power-on stretch counts core rising edges, then releases one clk later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      por_cnt       <= '0;
      sys_reset_n_q <= 1'b0;
    end else if (bus.en) begin
      if (boundary && (por_cnt != POR_MAX))
        por_cnt <= por_cnt + POR_W'(1);
      if (por_cnt == POR_MAX)
        sys_reset_n_q <= 1'b1;
    end
  end

  assign bus.clk_out     = clk_out_q;
  assign bus.rise_tick   = rise_q;
  assign bus.fall_tick   = fall_q;
  assign bus.sys_reset_n = sys_reset_n_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_clock_gen.sv
// Scoreboard bench for clock_gen: directed clk_out patterns are queued per edge
// and an independent monitor compares them against the DUT on the falling edge.
module tb_clock_gen;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  clock_gen_if #(.DIV_WIDTH(8)) bus ();

  clock_gen #(
    .DIV_WIDTH  (8),
    .DEFAULT_DIV(2),
    .POR_CYCLES (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic [35:0] exp;
  } exp_t;

  exp_t sb[$];

  int   checks   = 0;
  int   failures = 0;

  // Expectation state derived from the hand-written clk_out patterns.
  logic prev_clk;
  int   exp_cc;
  int   rises;
  logic exp_srn;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {clk_out, rise_tick, fall_tick, sys_reset_n, cycle_count}
  function automatic logic [35:0] observe();
    return {bus.clk_out, bus.rise_tick, bus.fall_tick, bus.sys_reset_n, bus.cycle_count};
  endfunction

  // One clk edge per pattern character; the character is clk_out after that edge.
  task automatic seg(input logic en_v, input logic [7:0] div_v, input string pat, input string name);
    for (int i = 0; i < pat.len(); i++) begin
      logic c;
      logic r;
      logic f;
      bus.en  = en_v;
      bus.div = div_v;
      @(posedge clk);
      c = (pat[i] == 8'h31);
      r = c & ~prev_clk;
      f = ~c & prev_clk;
      if (en_v && rises >= 4) exp_srn = 1'b1;
      if (r) begin
        exp_cc++;
        rises++;
      end
      prev_clk = c;
      sb.push_back('{$sformatf("%s[%0d]", name, i), {c, r, f, exp_srn, 32'(exp_cc)}});
      @(negedge clk);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, 64'(observe()), 64'(e.exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    bus.en   = 1'b0;
    bus.div  = 8'd2;
    prev_clk = 1'b0;
    exp_cc   = 0;
    rises    = 0;
    exp_srn  = 1'b0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 64'(observe()), 64'd0);

    reset = 1'b1;
    seg(1'b1, 8'd2, "10101010",   "default_por");
    seg(1'b1, 8'd5, "1110011100", "div5");
    seg(1'b1, 8'd5, "11",         "div5_head");
    seg(1'b1, 8'd3, "100",        "div5_tail");
    seg(1'b1, 8'd3, "110110",     "div3");
    seg(1'b1, 8'd0, "1010",       "div0");
    seg(1'b1, 8'd1, "1010",       "div1");
    seg(1'b1, 8'd5, "11",         "pre_freeze");
    seg(1'b0, 8'd5, "1111111",    "freeze");
    seg(1'b1, 8'd5, "1001110",    "resume");
    seg(1'b1, 8'd5, "01",         "pre_reset");

    // Assert reset between edges while clk_out is high and en is still 1.
    @(posedge clk);
    #1 check("pre_reset_high", 64'(bus.clk_out), 64'd1);
    #1 reset = 1'b0;
    #1 check("async_reset", 64'(observe()), 64'd0);
    repeat (3) @(negedge clk);
    check("reset_hold", 64'(observe()), 64'd0);

    prev_clk = 1'b0;
    exp_cc   = 0;
    rises    = 0;
    exp_srn  = 1'b0;
    reset    = 1'b1;
    seg(1'b1, 8'd2, "10101010", "por_again");

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
